// File: rtl/icache_set_assoc.sv
// N-way set-associative instruction cache with refill FSM; hits return combinationally, misses cost 2 + memory latency.
// Fetch is stalled (o_fetch_ready low) while a refill is in flight; refill request waits on i_mem_req_ready.
// Optional ICACHE_PERF_CNT_EN adds 64-bit hit/miss counters.
module icache_set_assoc #(
    parameter int WAYS        = 2,
    parameter int SET_COUNT   = 128,
    parameter int BLOCK_WIDTH = 512,
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   i_fetch_valid,
    input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
    output logic                   o_fetch_ready,
    output logic [WORD_SIZE-1:0]   o_instr,
    output logic                   o_instr_valid,
    output logic                   o_instr_addr_ma,
    input  logic                   i_invalidate,
    output logic                   o_mem_req_valid,
    output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
    input  logic                   i_mem_req_ready,
    input  logic                   i_mem_resp_valid,
    input  logic [BLOCK_WIDTH-1:0] i_mem_resp_data,
`ifdef ICACHE_PERF_CNT_EN
    output logic                   o_busy,
    output logic [63:0]            o_hit_cnt,
    output logic [63:0]            o_miss_cnt
`else
    output logic                   o_busy
`endif
);
    localparam int BO_W  = $clog2(WORD_SIZE / 8);
    localparam int WO_W  = $clog2(BLOCK_WIDTH / WORD_SIZE);
    localparam int IDX_W = $clog2(SET_COUNT);
    localparam int OFF_W = BO_W + WO_W;
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t state_q, state_d;
    logic                   inv_pend_q;
    logic [ADDR_WIDTH-1:0]  req_addr_q;
    logic [WAYS-1:0]        valid_q [SET_COUNT];
    logic [WAY_W-1:0]       vptr_q  [SET_COUNT];
    logic [TAG_W-1:0]       tag_q   [SET_COUNT][WAYS];
    logic [BLOCK_WIDTH-1:0] data_q  [SET_COUNT][WAYS];

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic [WO_W-1:0]  f_word;
    logic             misaligned;

    assign f_idx      = i_fetch_addr[OFF_W +: IDX_W];
    assign f_tag      = i_fetch_addr[ADDR_WIDTH-1 -: TAG_W];
    assign f_word     = i_fetch_addr[BO_W +: WO_W];
    assign misaligned = |i_fetch_addr[BO_W-1:0];
    assign r_idx      = req_addr_q[OFF_W +: IDX_W];
    assign r_tag      = req_addr_q[ADDR_WIDTH-1 -: TAG_W];

    logic [WAYS-1:0]      match;
    logic [WAY_W-1:0]     hit_way;
    logic                 hit;
    logic [WORD_SIZE-1:0] instr;

    // A hit requires exactly one matching way; duplicate tags are treated as a miss.
    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[f_idx][w] && (tag_q[f_idx][w] == f_tag);
            if (match[w]) hit_way = WAY_W'(w);
        end
        hit   = (match != '0) && ((match & (match - 1'b1)) == '0);
        instr = hit ? data_q[f_idx][hit_way][f_word * WORD_SIZE +: WORD_SIZE] : '0;
    end

    logic [WAY_W-1:0] victim;
    logic             use_ptr;

    // Lowest-index invalid way wins; the round-robin pointer only decides among full sets.
    always_comb begin
        victim  = vptr_q[r_idx];
        use_ptr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[r_idx][w]) begin
                victim  = WAY_W'(w);
                use_ptr = 1'b0;
            end
        end
    end

    logic idle, fetch_ok, start_miss, refill_done;

    assign idle        = (state_q == ST_IDLE);
    assign fetch_ok    = arstn && idle && i_fetch_valid && !i_invalidate;
    assign start_miss  = fetch_ok && !misaligned && !hit;
    assign refill_done = (state_q == ST_WAIT) && i_mem_resp_valid;

    assign o_fetch_ready   = fetch_ok && (misaligned || hit);
    assign o_instr_valid   = fetch_ok && !misaligned && hit;
    assign o_instr         = instr;
    assign o_instr_addr_ma = i_fetch_valid && misaligned;
    assign o_mem_req_valid = (state_q == ST_REQ);
    assign o_mem_req_addr  = req_addr_q;
    assign o_busy          = !idle;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_miss)       state_d = ST_REQ;
            ST_REQ:  if (i_mem_req_ready)  state_d = ST_WAIT;
            ST_WAIT: if (i_mem_resp_valid) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q    <= ST_IDLE;
            inv_pend_q <= 1'b0;
            req_addr_q <= '0;
            for (int s = 0; s < SET_COUNT; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start_miss)
                req_addr_q <= {i_fetch_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            if (idle && i_invalidate) begin
                for (int s = 0; s < SET_COUNT; s++) valid_q[s] <= '0;
            end else if (refill_done) begin
                // A fence seen mid-refill also wipes the line just written.
                if (inv_pend_q || i_invalidate) begin
                    for (int s = 0; s < SET_COUNT; s++) valid_q[s] <= '0;
                end else begin
                    valid_q[r_idx][victim] <= 1'b1;
                end
                if (use_ptr)
                    vptr_q[r_idx] <= (int'(vptr_q[r_idx]) == WAYS - 1) ? '0 : vptr_q[r_idx] + 1'b1;
            end
            if (refill_done)
                inv_pend_q <= 1'b0;
            else if (!idle && i_invalidate)
                inv_pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_q[r_idx][victim]  <= r_tag;
            data_q[r_idx][victim] <= i_mem_resp_data;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!arstn) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else begin
            if (o_instr_valid) o_hit_cnt  <= o_hit_cnt + 64'd1;
            if (start_miss)    o_miss_cnt <= o_miss_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_set_assoc.sv
// Scoreboard bench for icache_set_assoc: fetch results and refill addresses are queued when driven, checked when produced.
module tb_icache_set_assoc;
    localparam int AW = 64;
    localparam int BW = 512;
    localparam int WS = 32;

    logic          clk = 1'b0;
    logic          arstn;
    logic          i_fetch_valid;
    logic [AW-1:0] i_fetch_addr;
    logic          o_fetch_ready;
    logic [WS-1:0] o_instr;
    logic          o_instr_valid;
    logic          o_instr_addr_ma;
    logic          i_invalidate;
    logic          o_mem_req_valid;
    logic [AW-1:0] o_mem_req_addr;
    logic          i_mem_req_ready;
    logic          i_mem_resp_valid;
    logic [BW-1:0] i_mem_resp_data;
    logic          o_busy;
`ifdef ICACHE_PERF_CNT_EN
    logic [63:0]   o_hit_cnt;
    logic [63:0]   o_miss_cnt;
`endif
    logic          inv_main;
    logic          inv_resp;

    assign i_invalidate = inv_main | inv_resp;

    always #5 clk = ~clk;

    icache_set_assoc dut (
        .clk(clk), .arstn(arstn),
        .i_fetch_valid(i_fetch_valid), .i_fetch_addr(i_fetch_addr), .o_fetch_ready(o_fetch_ready),
        .o_instr(o_instr), .o_instr_valid(o_instr_valid), .o_instr_addr_ma(o_instr_addr_ma),
        .i_invalidate(i_invalidate),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr), .i_mem_req_ready(i_mem_req_ready),
        .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_data(i_mem_resp_data),
        .o_busy(o_busy)
`ifdef ICACHE_PERF_CNT_EN
        , .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        vld;
        logic        ma;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] req_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt = 0;
    int req_stall = 0;
    int resp_lat = 0;
    int inv_at_hs = -1;
    longint exp_hit_cnt = 0;
    longint exp_miss_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0013;
    endfunction

    function automatic logic [BW-1:0] mem_block(input logic [63:0] a);
        logic [BW-1:0] b;
        for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = mem_word(a + 64'(4 * k));
        return b;
    endfunction

    // One fetch: expected result and refill addresses are queued first, then checked on o_fetch_ready.
    task automatic fetch(input logic [63:0] addr, input logic vld, input logic ma,
                         input int misses, input int cycles);
        exp_t e;
        int   hs0;
        int   waited;
        e.instr = mem_word({addr[63:2], 2'b00});
        e.vld   = vld;
        e.ma    = ma;
        exp_q.push_back(e);
        for (int i = 0; i < misses; i++) req_q.push_back({addr[63:6], 6'b0});
        if (vld) exp_hit_cnt++;
        exp_miss_cnt += longint'(misses);
        hs0 = hs_cnt;
        @(negedge clk);
        i_fetch_valid = 1'b1;
        i_fetch_addr  = addr;
        #1;
        waited = 0;
        while (!o_fetch_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("fetch_ready", 64'(o_fetch_ready), 64'd1);
        e = exp_q.pop_front();
        if (o_fetch_ready) begin
            chk("instr_valid", 64'(o_instr_valid), 64'(e.vld));
            chk("addr_ma", 64'(o_instr_addr_ma), 64'(e.ma));
            if (e.vld) chk("instr", 64'(o_instr), 64'(e.instr));
            if (cycles >= 0) chk("latency", 64'(waited), 64'(cycles));
        end
        @(posedge clk);
        #1;
        i_fetch_valid = 1'b0;
        chk("refill_count", 64'(hs_cnt - hs0), 64'(misses));
    endtask

    // Memory model: optional request stall, response latency and an invalidate pulse in WAIT.
    initial begin
        logic [63:0] ea;
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data  = '0;
        inv_resp         = 1'b0;
        forever begin
            @(negedge clk);
            if (arstn && o_mem_req_valid) begin
                ea = (req_q.size() > 0) ? req_q[0] : '1;
                for (int i = 0; i < req_stall; i++) begin
                    chk("req_stall_addr", o_mem_req_addr, ea);
                    chk("req_stall_state", 64'({o_busy, o_mem_req_valid, o_fetch_ready}), 64'(3'b110));
                    @(negedge clk);
                end
                chk("req_addr", o_mem_req_addr, ea);
                if (req_q.size() > 0) void'(req_q.pop_front());
                i_mem_req_ready = 1'b1;
                hs_cnt++;
                @(negedge clk);
                i_mem_req_ready = 1'b0;
                for (int i = 0; i < resp_lat; i++) begin
                    inv_resp = (hs_cnt == inv_at_hs) && (i == 0);
                    @(negedge clk);
                end
                inv_resp         = 1'b0;
                i_mem_resp_valid = 1'b1;
                i_mem_resp_data  = mem_block(ea);
                @(negedge clk);
                i_mem_resp_valid = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arstn         = 1'b0;
        inv_main      = 1'b0;
        i_fetch_valid = 1'b1;
        i_fetch_addr  = 64'h8000_0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_fetch_ready", 64'(o_fetch_ready), 64'd0);
        chk("rst_instr_valid", 64'(o_instr_valid), 64'd0);
        chk("rst_mem_req_valid", 64'(o_mem_req_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        @(negedge clk);
        arstn         = 1'b1;
        i_fetch_valid = 1'b0;

        fetch(64'h8000_0000, 1'b1, 1'b0, 1, 3);
        fetch(64'h8000_003C, 1'b1, 1'b0, 0, 0);

        // Invalidate beats a simultaneous hitting fetch; the line is gone next cycle.
        @(negedge clk);
        i_fetch_valid = 1'b1;
        i_fetch_addr  = 64'h8000_0000;
        inv_main      = 1'b1;
        #1;
        chk("inv_fetch_ready", 64'(o_fetch_ready), 64'd0);
        chk("inv_instr_valid", 64'(o_instr_valid), 64'd0);
        @(posedge clk);
        #1;
        inv_main      = 1'b0;
        i_fetch_valid = 1'b0;
        fetch(64'h8000_0000, 1'b1, 1'b0, 1, 3);

        fetch(64'h8000_0002, 1'b0, 1'b1, 0, 0);

        @(negedge clk);
        inv_main = 1'b1;
        @(negedge clk);
        inv_main = 1'b0;

        // Three blocks in set 0 of a 2-way cache: the third evicts way0.
        fetch(64'h0000_0000, 1'b1, 1'b0, 1, 3);
        fetch(64'h0000_2000, 1'b1, 1'b0, 1, 3);
        fetch(64'h0000_4000, 1'b1, 1'b0, 1, 3);
        fetch(64'h0000_2000, 1'b1, 1'b0, 0, 0);
        fetch(64'h0000_4004, 1'b1, 1'b0, 0, 0);
        fetch(64'h0000_0000, 1'b1, 1'b0, 1, 3);

        // Stalled request plus invalidate in WAIT forces a second refill.
        req_stall = 5;
        resp_lat  = 2;
        inv_at_hs = hs_cnt + 1;
        fetch(64'h0000_1040, 1'b1, 1'b0, 2, -1);
        req_stall = 0;
        resp_lat  = 1;
        inv_at_hs = -1;
        fetch(64'h0000_1048, 1'b1, 1'b0, 0, 0);
        fetch(64'h0000_1080, 1'b1, 1'b0, 1, 4);

`ifdef ICACHE_PERF_CNT_EN
        @(negedge clk);
        chk("hit_cnt", o_hit_cnt, 64'(exp_hit_cnt));
        chk("miss_cnt", o_miss_cnt, 64'(exp_miss_cnt));
`endif
        chk("req_queue_empty", 64'(req_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/icache_set_assoc.md
Name: icache_set_assoc

Overview:
- Parametrised N-way set-associative instruction cache with an integrated refill FSM; successor to the direct-mapped instruction cache.
- Sits between the fetch stage and the memory/AXI bridge.
- Hits return in the same cycle. Misses issue one block request over a valid/ready handshake and are written into a victim way chosen round-robin per set.
- Supports a fence.i-style global invalidate.

Parameters:
- WAYS, 2, associativity (power of two, 1..8).
- SET_COUNT, 128, number of sets (power of two).
- BLOCK_WIDTH, 512, bits per cache line.
- WORD_SIZE, 32, instruction width.
- ADDR_WIDTH, 64, fetch address width.

Ports:
- clk  in  1  clock
- arstn  in  1  synchronous active-low reset
- i_fetch_valid  in  1  fetch request valid
- i_fetch_addr  in  ADDR_WIDTH  fetch address
- o_fetch_ready  out  1  request accepted this cycle
- o_instr  out  WORD_SIZE  instruction word
- o_instr_valid  out  1  o_instr valid (hit)
- o_instr_addr_ma  out  1  misaligned fetch, |i_fetch_addr[1:0]
- i_invalidate  in  1  invalidate all lines
- o_mem_req_valid  out  1  block refill request
- o_mem_req_addr  out  ADDR_WIDTH  block-aligned refill address
- i_mem_req_ready  in  1  memory accepts request
- i_mem_resp_valid  in  1  refill data valid
- i_mem_resp_data  in  BLOCK_WIDTH  refill block
- o_busy  out  1  FSM not IDLE

Behaviour:
- Address split:
  - byte offset = log2(WORD_SIZE/8) bits.
  - word offset = log2(BLOCK_WIDTH/WORD_SIZE) bits.
  - index = log2(SET_COUNT) bits.
  - tag = remaining upper bits.
- Per-set storage: WAYS x {valid, tag, data}, plus a log2(WAYS)-bit victim pointer (0 bits when WAYS=1).
- Reset (arstn=0 at posedge):
  - All valid bits and victim pointers cleared; FSM=IDLE; invalidate-pending flag cleared.
  - o_mem_req_valid=0, o_busy=0.
  - While in reset: o_fetch_ready=0, o_instr_valid=0.
  - Tag/data arrays are not reset.
  - Reset mid-refill abandons the request; a later i_mem_resp_valid is ignored in IDLE.
- Lookup is combinational, compared across all ways.
  - hit = exactly one way with valid and tag match.
  - o_instr = selected word of the hit way; o_instr = 0 when not hit.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - fetch_valid & misaligned: o_instr_addr_ma=1, o_fetch_ready=1, o_instr_valid=0. No refill.
  - fetch_valid & hit: o_instr_valid=1, o_fetch_ready=1. Zero-cycle latency.
  - fetch_valid & miss: o_fetch_ready=0. Latch the block-aligned address, then go to REQ.
  - i_invalidate in IDLE: all valid bits cleared at the edge. That cycle o_instr_valid=0 and o_fetch_ready=0; invalidate wins over a simultaneous fetch.
- REQ:
  - o_mem_req_valid=1 and o_mem_req_addr held stable until i_mem_req_ready.
  - On the handshake edge, go to WAIT.
- WAIT:
  - On i_mem_resp_valid, write the block, tag and valid=1 into the victim way, then go to IDLE.
  - Victim = lowest-index invalid way if any; otherwise the victim pointer. Pointer increments (wraps modulo WAYS) only when the pointer was used.
- Fetch-side rules:
  - The requester holds i_fetch_valid and i_fetch_addr stable until o_fetch_ready.
  - After a refill the same address hits in IDLE. Miss penalty = 2 + memory latency cycles.
- i_invalidate during REQ/WAIT sets the pending flag. On refill completion the block is written, then all valid bits (including the new line) are cleared. The flag clears and the FSM returns to IDLE, where the fetch misses again.
- o_fetch_ready=0 and o_instr_valid=0 in REQ/WAIT.
- o_busy=1 in REQ/WAIT.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN adds outputs o_hit_cnt[63:0] and o_miss_cnt[63:0].
  - o_hit_cnt increments on each accepted hit.
  - o_miss_cnt increments on each IDLE->REQ transition.
  - Both reset to 0 and wrap at 2^64.
- Without the macro the ports and counters do not exist; functional behaviour is identical.

Test Plan:
- Reset, then fetch 0x8000_0000 -> o_instr_valid=0, o_mem_req_valid=1 after 1 cycle, o_mem_req_addr=0x8000_0000. Respond with block word0=0x0000_0013 -> next IDLE cycle o_instr=0x13, o_instr_valid=1.
- Same block, fetch 0x8000_003C -> immediate hit, o_instr = word15 of the refilled block; no memory request.
- WAYS=2: fill addresses 0x0000, 0x2000 and 0x4000 (same index) -> third refill goes to way0 (pointer 0→1); refetch 0x0000 misses, 0x2000 hits.
- Fetch 0x8000_0002 -> o_instr_addr_ma=1, o_fetch_ready=1, no o_mem_req_valid.
- Hold i_mem_req_ready=0 for 5 cycles -> address stable, state REQ. Pulse i_invalidate during WAIT -> after the response the line is invalid and the same fetch misses again.
- i_invalidate together with a hitting fetch in IDLE -> o_instr_valid=0; the next cycle the fetch misses.
